// File: rtl/mem_arbiter_if.sv
// Bundle of fetch-side, data-side and memory-side signals around mem_arbiter.
// The arbiter uses the slave modport and the requesters/memory use the master modport.
interface mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_done;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_rdata, i_done, d_rdata, d_done,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_rdata, i_done, d_rdata, d_done,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises fetch and data accesses onto one fixed-latency memory port.
// Data has priority; a wait counter forces a fetch grant after STARVE_LIMIT data wins.
module mem_arbiter #(
  parameter int unsigned LATENCY      = 2,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);
  localparam logic [3:0] LAT_LOAD  = 4'(LATENCY);
  localparam logic [3:0] STARVE_TH = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt, lat_cnt;
  logic        grant_d, we_q;
  logic [31:0] addr_q, wdata_q, i_rdata_q, d_rdata_q;
  logic        any_req, pick_d, lat_last;

  always_comb begin
    any_req  = bus.i_req | bus.d_req;
    pick_d   = bus.d_req & ~(bus.i_req & (wait_cnt >= STARVE_TH));
    lat_last = (lat_cnt == 4'd1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    bus.mem_en = 1'b0;
    bus.i_done = 1'b0;
    bus.d_done = 1'b0;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE: begin
        bus.mem_en = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT:    if (lat_last) state_nxt = DONE;
      DONE: begin
        bus.i_done = ~grant_d;
        bus.d_done = grant_d;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt  <= '0;
      lat_cnt   <= '0;
      grant_d   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          grant_d <= pick_d;
          we_q    <= pick_d & bus.d_we;
          addr_q  <= pick_d ? bus.d_addr : bus.i_addr;
          wdata_q <= pick_d ? bus.d_wdata : '0;
          // Only a data win over a waiting fetch counts towards starvation.
          if (pick_d && bus.i_req) begin
            if (wait_cnt != 4'hF) wait_cnt <= wait_cnt + 4'd1;
          end else begin
            wait_cnt <= '0;
          end
        end
        ISSUE: lat_cnt <= LAT_LOAD;
        WAIT: begin
          lat_cnt <= lat_cnt - 4'd1;
          if (lat_last) begin
            if (!grant_d)   i_rdata_q <= bus.mem_rdata;
            else if (!we_q) d_rdata_q <= bus.mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Address and write data stay parked on the bus; only the write strobe is gated.
  assign bus.mem_we    = we_q & (state == ISSUE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: dut0 at LATENCY=2, dut1 at LATENCY=1, each on a memory model
// whose read data is valid only in the single cycle LATENCY cycles after mem_en.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if if0();
  mem_arbiter_if if1();

  mem_arbiter #(.LATENCY(2), .STARVE_LIMIT(3)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
  mem_arbiter #(.LATENCY(1), .STARVE_LIMIT(3)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

  typedef struct { logic side_d; logic [31:0] data; int cyc; } exp_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic [31:0] data; int cyc; } job_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  exp_t        sb0_i[$], sb0_d[$], sb1[$];
  exp_t        m0e, m1e;
  job_t        d_jobs[$];
  logic [31:0] wmem [logic [31:0]];
  logic [31:0] last_d = '0;

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (wmem.exists(a)) return wmem[a];
    return a ^ 32'h5A5A_C3C3;
  endfunction

  // Memory models
  logic        p0_v0 = 1'b0, p0_v1 = 1'b0, p1_v0 = 1'b0;
  logic [31:0] p0_d0 = '0, p0_d1 = '0, p1_d0 = '0;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    p0_v0 <= if0.mem_en & ~if0.mem_we;
    p0_d0 <= rd(if0.mem_addr);
    p0_v1 <= p0_v0;
    p0_d1 <= p0_d0;
    p1_v0 <= if1.mem_en & ~if1.mem_we;
    p1_d0 <= rd(if1.mem_addr);
    if (if0.mem_en && if0.mem_we) wmem[if0.mem_addr] = if0.mem_wdata;
  end
  assign if0.mem_rdata = p0_v1 ? p0_d1 : 32'hDEAD_BEEF;
  assign if1.mem_rdata = p1_v0 ? p1_d0 : 32'hDEAD_BEEF;

  // Scoreboard for dut0
  always @(negedge clk) begin
    if (if0.i_done || if0.d_done) begin
      checks++;
      if (if0.i_done && if0.d_done) begin
        errors++;
        $display("FAIL done_overlap0: i_done=1 and d_done=1 at cycle %0d, required at most one", cyc);
      end
    end
    if (if0.i_done) begin
      checks++;
      if (sb0_i.size() == 0) begin
        errors++;
        $display("FAIL i_done_unexpected0: i_done at cycle %0d, required none outstanding", cyc);
      end else begin
        m0e = sb0_i.pop_front();
        if (if0.i_rdata !== m0e.data || cyc != m0e.cyc) begin
          errors++;
          $display("FAIL i_read0: got %h at cycle %0d, required %h at cycle %0d", if0.i_rdata, cyc, m0e.data, m0e.cyc);
        end
      end
    end
    if (if0.d_done) begin
      checks++;
      if (sb0_d.size() == 0) begin
        errors++;
        $display("FAIL d_done_unexpected0: d_done at cycle %0d, required none outstanding", cyc);
      end else begin
        m0e = sb0_d.pop_front();
        if (if0.d_rdata !== m0e.data || cyc != m0e.cyc) begin
          errors++;
          $display("FAIL d_access0: got %h at cycle %0d, required %h at cycle %0d", if0.d_rdata, cyc, m0e.data, m0e.cyc);
        end
      end
    end
  end

  // Scoreboard for dut1
  always @(negedge clk) begin
    if (if1.i_done || if1.d_done) begin
      checks++;
      if (if1.i_done && if1.d_done) begin
        errors++;
        $display("FAIL done_overlap1: i_done=1 and d_done=1 at cycle %0d, required at most one", cyc);
      end else if (sb1.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected1: done at cycle %0d, required none outstanding", cyc);
      end else begin
        m1e = sb1.pop_front();
        if (if1.d_done !== m1e.side_d || cyc != m1e.cyc ||
            (m1e.side_d ? if1.d_rdata : if1.i_rdata) !== m1e.data) begin
          errors++;
          $display("FAIL access1: got side_d=%0b data %h/%h at cycle %0d, required side_d=%0b data %h at cycle %0d",
                   if1.d_done, if1.i_rdata, if1.d_rdata, cyc, m1e.side_d, m1e.data, m1e.cyc);
        end
      end
    end
  end

  task automatic start_i(input logic [31:0] a, input logic [31:0] data, input int c);
    if0.i_addr = a;
    if0.i_req  = 1'b1;
    sb0_i.push_back('{1'b0, data, c});
  endtask

  task automatic start_d(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] data, input int c);
    if0.d_we    = we;
    if0.d_addr  = a;
    if0.d_wdata = wd;
    if0.d_req   = 1'b1;
    sb0_d.push_back('{1'b1, data, c});
    if (!we) last_d = data;
  endtask

  // One cycle of dut0 requester behaviour: drop or replace a request on its done.
  task automatic tick0();
    job_t j;
    @(negedge clk);
    if (if0.i_done) if0.i_req = 1'b0;
    if (if0.d_done) begin
      if (d_jobs.size() > 0) begin
        j = d_jobs.pop_front();
        start_d(j.we, j.addr, j.wdata, j.data, j.cyc);
      end else begin
        if0.d_req = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({if0.mem_en, if0.mem_we, if0.i_done, if0.d_done, if0.busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl0: got %b, required 00000", {if0.mem_en, if0.mem_we, if0.i_done, if0.d_done, if0.busy});
    end
    checks++;
    if ({if0.mem_addr, if0.mem_wdata, if0.i_rdata, if0.d_rdata} !== 128'b0) begin
      errors++;
      $display("FAIL reset_data0: got %h, required 0", {if0.mem_addr, if0.mem_wdata, if0.i_rdata, if0.d_rdata});
    end
    checks++;
    if ({if1.mem_en, if1.mem_we, if1.i_done, if1.d_done, if1.busy, if1.mem_addr, if1.i_rdata, if1.d_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_all1: got %h, required 0", {if1.mem_en, if1.mem_we, if1.i_done, if1.d_done, if1.busy, if1.mem_addr, if1.i_rdata, if1.d_rdata});
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (if0.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy0: got %b, required 0", if0.busy);
    end
  endtask

  task automatic test_single_fetch();
    int t0 = cyc;
    start_i(32'h0000_0010, 32'h8C02_0004, t0 + 4);
    for (int k = 1; k <= 5; k++) begin
      tick0();
      checks++;
      if (if0.busy !== (k <= 4) || if0.mem_en !== (k == 1)) begin
        errors++;
        $display("FAIL fetch_busy_en k=%0d: got busy=%b mem_en=%b, required busy=%b mem_en=%b",
                 k, if0.busy, if0.mem_en, (k <= 4), (k == 1));
      end
      if (k == 1) begin
        checks++;
        if (if0.mem_addr !== 32'h10) begin
          errors++;
          $display("FAIL fetch_addr: got %h, required 00000010", if0.mem_addr);
        end
      end
    end
  endtask

  task automatic test_priority();
    int t0 = cyc;
    start_i(32'h20, rd(32'h20), t0 + 9);
    start_d(1'b0, 32'h40, '0, rd(32'h40), t0 + 4);
    for (int k = 1; k <= 10; k++) begin
      tick0();
      if (k == 1 || k == 6) begin
        checks++;
        if (if0.mem_en !== 1'b1 || if0.mem_addr !== ((k == 1) ? 32'h40 : 32'h20)) begin
          errors++;
          $display("FAIL priority_issue k=%0d: got en=%b addr=%h, required en=1 addr=%h",
                   k, if0.mem_en, if0.mem_addr, (k == 1) ? 32'h40 : 32'h20);
        end
      end
    end
    checks++;
    if (if0.busy !== 1'b0) begin
      errors++;
      $display("FAIL priority_idle: got busy=%b, required 0", if0.busy);
    end
  endtask

  task automatic test_starvation();
    int t0 = cyc;
    logic [31:0] exp_addr [5];
    exp_addr = '{32'h100, 32'h104, 32'h108, 32'h200, 32'h10C};
    start_i(32'h200, rd(32'h200), t0 + 19);
    start_d(1'b0, 32'h100, '0, rd(32'h100), t0 + 4);
    d_jobs.push_back('{1'b0, 32'h104, 32'h0, rd(32'h104), t0 + 9});
    d_jobs.push_back('{1'b0, 32'h108, 32'h0, rd(32'h108), t0 + 14});
    d_jobs.push_back('{1'b0, 32'h10C, 32'h0, rd(32'h10C), t0 + 24});
    for (int k = 1; k <= 25; k++) begin
      tick0();
      if (k % 5 == 1) begin
        checks++;
        if (if0.mem_en !== 1'b1 || if0.mem_addr !== exp_addr[k / 5]) begin
          errors++;
          $display("FAIL starve_grant k=%0d: got en=%b addr=%h, required en=1 addr=%h",
                   k, if0.mem_en, if0.mem_addr, exp_addr[k / 5]);
        end
      end
      if (k == 15 || k == 16) begin
        checks++;
        if (dut0.wait_cnt !== ((k == 15) ? 4'd3 : 4'd0)) begin
          errors++;
          $display("FAIL starve_wait_cnt k=%0d: got %0d, required %0d", k, dut0.wait_cnt, (k == 15) ? 3 : 0);
        end
      end
    end
    checks++;
    if (if0.busy !== 1'b0) begin
      errors++;
      $display("FAIL starve_idle: got busy=%b, required 0", if0.busy);
    end
  endtask

  task automatic test_write();
    int t0 = cyc;
    start_d(1'b1, 32'h54, 32'h7, last_d, t0 + 4);
    d_jobs.push_back('{1'b0, 32'h54, 32'h0, 32'h7, t0 + 9});
    for (int k = 1; k <= 10; k++) begin
      tick0();
      checks++;
      if (if0.mem_we !== (k == 1)) begin
        errors++;
        $display("FAIL write_we k=%0d: got %b, required %b", k, if0.mem_we, (k == 1));
      end
      if (k == 1) begin
        checks++;
        if (if0.mem_en !== 1'b1 || if0.mem_addr !== 32'h54 || if0.mem_wdata !== 32'h7) begin
          errors++;
          $display("FAIL write_issue: got en=%b addr=%h wdata=%h, required en=1 addr=00000054 wdata=00000007",
                   if0.mem_en, if0.mem_addr, if0.mem_wdata);
        end
      end
    end
  endtask

  task automatic test_reset_mid_access();
    int t1;
    if0.i_addr = 32'h300;
    if0.i_req  = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({if0.mem_en, if0.mem_we, if0.busy, if0.i_done, if0.d_done} !== 5'b0) begin
      errors++;
      $display("FAIL midreset_ctrl: got %b, required 00000", {if0.mem_en, if0.mem_we, if0.busy, if0.i_done, if0.d_done});
    end
    checks++;
    if ({if0.mem_addr, if0.mem_wdata, if0.i_rdata, if0.d_rdata} !== 128'b0) begin
      errors++;
      $display("FAIL midreset_data: got %h, required 0", {if0.mem_addr, if0.mem_wdata, if0.i_rdata, if0.d_rdata});
    end
    if0.i_req = 1'b0;
    last_d    = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    t1 = cyc;
    start_i(32'h304, rd(32'h304), t1 + 4);
    for (int k = 1; k <= 5; k++) begin
      tick0();
      if (k == 1) begin
        checks++;
        if (if0.mem_en !== 1'b1 || if0.mem_addr !== 32'h304) begin
          errors++;
          $display("FAIL postreset_issue: got en=%b addr=%h, required en=1 addr=00000304", if0.mem_en, if0.mem_addr);
        end
      end
    end
  endtask

  task automatic test_latency1();
    int t0 = cyc;
    int n = 0;
    logic [31:0] a;
    if1.i_addr = 32'h400;
    if1.i_req  = 1'b1;
    sb1.push_back('{1'b0, rd(32'h400), t0 + 3});
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      checks++;
      if (if1.mem_en !== (k % 4 == 1)) begin
        errors++;
        $display("FAIL lat1_mem_en k=%0d: got %b, required %b", k, if1.mem_en, (k % 4 == 1));
      end
      if (if1.i_done || if1.d_done) begin
        if1.i_req = 1'b0;
        if1.d_req = 1'b0;
        n++;
        if (n < 4) begin
          a = 32'h400 + 32'(4 * n);
          if (n % 2 == 0) begin
            if1.i_addr = a;
            if1.i_req  = 1'b1;
          end else begin
            if1.d_we   = 1'b0;
            if1.d_addr = a;
            if1.d_req  = 1'b1;
          end
          sb1.push_back('{(n % 2 == 1), rd(a), t0 + 4 * n + 3});
        end
      end
    end
    checks++;
    if (if1.busy !== 1'b0) begin
      errors++;
      $display("FAIL lat1_idle: got busy=%b, required 0", if1.busy);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    {if0.i_req, if0.d_req, if0.d_we} = '0;
    {if0.i_addr, if0.d_addr, if0.d_wdata} = '0;
    {if1.i_req, if1.d_req, if1.d_we} = '0;
    {if1.i_addr, if1.d_addr, if1.d_wdata} = '0;
    wmem[32'h10] = 32'h8C02_0004;
    repeat (3) @(negedge clk);
    test_reset();
    test_single_fetch();
    test_priority();
    test_starvation();
    test_write();
    test_reset_mid_access();
    test_latency1();
    repeat (2) @(negedge clk);
    checks++;
    if (sb0_i.size() + sb0_d.size() + sb1.size() != 0) begin
      errors++;
      $display("FAIL outstanding: got %0d accesses never completed, required 0", sb0_i.size() + sb0_d.size() + sb1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-ported, fixed-latency unified memory between the core's instruction-fetch side and data side. Sits between the mips_core fetch/data interfaces and the memory macro. Serialises accesses through a small FSM and returns a one-cycle done pulse with read data to the requester. Data accesses have priority, with an anti-starvation counter that guarantees fetch progress.

Parameters:
LATENCY, 2, cycles from mem_en to valid mem_rdata (legal range 1..15)
STARVE_LIMIT, 3, consecutive data grants with i_req pending before fetch is forced (legal range 1..15)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
i_req  in  1  fetch request; held with i_addr stable until i_done
i_addr  in  32  fetch byte address
i_rdata  out  32  fetch read data; valid when i_done=1
i_done  out  1  one-cycle completion pulse for fetch
d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_done
d_we  in  1  1=write, 0=read
d_addr  in  32  data byte address
d_wdata  in  32  write data
d_rdata  out  32  data read data; valid when d_done=1 and the access was a read
d_done  out  1  one-cycle completion pulse for data
mem_en  out  1  memory access strobe, one cycle per access
mem_we  out  1  memory write enable
mem_addr  out  32  memory address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, valid LATENCY cycles after mem_en
busy  out  1  1 when state != IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs 0; wait counter, latency counter, grant and holding registers 0. Reset mid-access aborts it: mem_en/mem_we drop immediately, no done pulse is issued, and the memory result is discarded.
- States: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE: arbitrate on current i_req/d_req. If no request, stay in IDLE. Otherwise, latch the grant, address, write enable (0 for fetch) and write data into holding regs and go to ISSUE at the next edge.
- Arbitration:
  - Only d_req set: grant D.
  - Only i_req set: grant I.
  - Both set: grant D, unless wait_cnt >= STARVE_LIMIT, in which case grant I.
- wait_cnt (4-bit, saturating at 15): updated in IDLE when a grant is made.
  - Increments when D is granted while i_req=1.
  - Clears when I is granted, or when D is granted with i_req=0.
- ISSUE (1 cycle): mem_en=1; mem_we/mem_addr/mem_wdata come from the holding regs. Load the latency counter with LATENCY, then go to WAIT.
- WAIT (exactly LATENCY cycles): mem_en=0. mem_addr/mem_we/mem_wdata stay held, but mem_we is forced 0 outside ISSUE. When the counter expires, capture mem_rdata into the granted side's rdata register (reads only) and go to DONE.
- DONE (1 cycle): granted side's done=1. The rdata register holds until that side's next read completes. Writes pulse d_done and leave d_rdata unchanged. No arbitration happens in DONE.
- Requester handshake: the requester drops req, or presents a new request, at the edge ending its done cycle. The next IDLE cycle arbitrates fresh.
- Deasserting req before done is a protocol violation. The access still completes and done still pulses.
- Per-access occupancy: LATENCY+3 cycles (IDLE, ISSUE, WAIT×LATENCY, DONE). Back-to-back throughput is one access per LATENCY+3 cycles.
- i_done and d_done are never high in the same cycle. mem_en is never high outside ISSUE.
- Address and data pass through unmodified at full 32 bits; no alignment check is done.

Test Plan:
- LATENCY=2, i_req=1 with i_addr=0x00000010 at cycle 0 -> mem_en=1, mem_addr=0x10 at cycle 1; bench drives mem_rdata=0x8C020004 at cycle 3 -> i_done=1, i_rdata=0x8C020004 at cycle 4; busy=1 during cycles 1–4.
- i_req and d_req both rise at cycle 0 (d_we=0, d_addr=0x40) -> mem_addr=0x40 at cycle 1 and d_done at cycle 4; fetch is served next with mem_addr=i_addr at cycle 6 and i_done at cycle 9.
- STARVE_LIMIT=3, d_req held continuously with i_req pending -> three data accesses complete, the fourth grant goes to fetch, then data resumes; wait_cnt returns to 0 after the fetch grant.
- Data write: d_we=1, d_addr=0x54, d_wdata=0x00000007 -> mem_we=1 only in the ISSUE cycle, mem_wdata=0x7, d_done pulses at ISSUE+LATENCY+1, and d_rdata keeps its prior value.
- Reset asserted during WAIT -> mem_en=0, busy=0 and all outputs 0 immediately; no done pulse; after release, a new i_req is granted normally.
- LATENCY=1, alternating single fetch/data reads -> each access occupies 4 cycles, i_done and d_done never overlap, and rdata is captured from mem_rdata one cycle after mem_en.
